// File: rtl/mercury2_adc_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mercury2_adc_reader_if
// Description : Host-side handshake bundle for the Mercury2 ADC reader:
//               trigger/command in, Busy/result/status out.
// Revision    : 1.0  initial release
// ============================================================================
interface mercury2_adc_reader_if;
    logic       trigger;
    logic [2:0] channel;
    logic       single_ended;
    logic       Busy;
    logic [9:0] Dout;
    logic       DataValid;
    logic       NullBitError;

    // Host that requests conversions
    modport master (
        output trigger, channel, single_ended,
        input  Busy, Dout, DataValid, NullBitError
    );

    // ADC reader that services them
    modport slave (
        input  trigger, channel, single_ended,
        output Busy, Dout, DataValid, NullBitError
    );
endinterface
`default_nettype wire

// File: rtl/mercury2_adc_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mercury2_adc_reader
// Description : SPI master reading one 10-bit conversion from the Mercury2
//               MCP3008-style ADC per trigger. Sends start/mode/channel
//               command, captures null bit and D9..D0, then holds chip select
//               high for CsHighClocks before releasing Busy.
//               ClockFreq/(2*SckFreq) must be an integer >= 2;
//               CsHighClocks must be >= 1.
// Revision    : 1.0  initial release
// ============================================================================
module mercury2_adc_reader #(
    parameter int ClockFreq    = 50_000_000,
    parameter int SckFreq      = 1_000_000,
    parameter int CsHighClocks = 50
) (
    input  wire logic            clk_50MHZ,
    input  wire logic            reset,
    mercury2_adc_reader_if.slave host,
    output logic                 adc_csn,
    output logic                 adc_sck,
    output logic                 adc_din,
    input  wire logic            adc_dout
);

    // Clocks per SCK half-period
    localparam int H       = ClockFreq / (2 * SckFreq);
    localparam int CNT_MAX = (H > CsHighClocks) ? H : CsHighClocks;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] CSH_LAST  = CW'(CsHighClocks - 1);

    // SCK pulse numbering: 1 = start bit, 7 = null bit, 17 = D0
    localparam logic [4:0] NULL_BIT  = 5'd7;
    localparam logic [4:0] FIRST_DAT = 5'd8;
    localparam logic [4:0] LAST_BIT  = 5'd17;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SCK_HIGH = 3'd2;
    localparam logic [2:0] S_SCK_LOW  = 3'd3;
    localparam logic [2:0] S_CS_HIGH  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;

    logic [3:0]    cmd_q, cmd_d;       // {single_ended, channel[2:0]}
    logic [9:0]    shift_q, shift_d;
    logic          null_q, null_d;

    logic          csn_q, csn_d;
    logic          sck_q, sck_d;
    logic          din_q, din_d;
    logic          busy_q, busy_d;
    logic [9:0]    dout_q, dout_d;
    logic          dv_q, dv_d;
    logic          nerr_q, nerr_d;

    logic          w_half_done;
    logic          w_csh_done;
    logic [4:0]    w_bit_next;
    logic          w_din_next;

    assign w_half_done = (cnt_q == HALF_LAST);
    assign w_csh_done  = (cnt_q == CSH_LAST);
    assign w_bit_next  = bit_q + 5'd1;

    // Command bit to present for the upcoming SCK pulse (after falling edge k)
    always_comb begin
        w_din_next = 1'b0;
        case (w_bit_next)
            5'd2:    w_din_next = cmd_q[3];
            5'd3:    w_din_next = cmd_q[2];
            5'd4:    w_din_next = cmd_q[1];
            5'd5:    w_din_next = cmd_q[0];
            default: w_din_next = 1'b0;
        endcase
    end

    // State, phase counter and pulse index registers
    always_ff @(posedge clk_50MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state: each SCK phase and the CS-high gap are timed by cnt_q
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (host.trigger) begin
                    state_d = S_SETUP;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (w_half_done) begin
                    state_d = S_SCK_HIGH;
                    cnt_d   = '0;
                    bit_d   = 5'd1;
                end
            end
            S_SCK_HIGH: begin
                if (w_half_done) begin
                    cnt_d   = '0;
                    state_d = (bit_q == LAST_BIT) ? S_CS_HIGH : S_SCK_LOW;
                end
            end
            S_SCK_LOW: begin
                if (w_half_done) begin
                    cnt_d   = '0;
                    state_d = S_SCK_HIGH;
                    bit_d   = w_bit_next;
                end
            end
            S_CS_HIGH: begin
                if (w_csh_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output/datapath next values; outputs change on the same edge as the state
    always_comb begin
        cmd_d   = cmd_q;
        shift_d = shift_q;
        null_d  = null_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        din_d   = din_q;
        busy_d  = busy_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        nerr_d  = nerr_q;
        case (state_q)
            S_IDLE: begin
                if (host.trigger) begin
                    cmd_d  = {host.single_ended, host.channel};
                    csn_d  = 1'b0;
                    busy_d = 1'b1;
                    din_d  = 1'b1;      // start bit
                end
            end
            S_SETUP: begin
                if (w_half_done) begin
                    sck_d = 1'b1;       // rising edge 1, nothing to sample
                end
            end
            S_SCK_HIGH: begin
                if (w_half_done) begin
                    sck_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        csn_d  = 1'b1;
                        din_d  = 1'b0;
                        dout_d = shift_q;
                        dv_d   = 1'b1;
                        nerr_d = null_q;
                    end else begin
                        din_d = w_din_next;
                    end
                end
            end
            S_SCK_LOW: begin
                if (w_half_done) begin
                    sck_d = 1'b1;
                    // Edge 6 is the ADC sample window; capture starts at 7
                    if (w_bit_next == NULL_BIT) begin
                        null_d = adc_dout;
                    end else if (w_bit_next >= FIRST_DAT) begin
                        shift_d = {shift_q[8:0], adc_dout};
                    end
                end
            end
            S_CS_HIGH: begin
                if (w_csh_done) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                csn_d  = 1'b1;
                sck_d  = 1'b0;
                din_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk_50MHZ or posedge reset) begin
        if (reset) begin
            cmd_q   <= '0;
            shift_q <= '0;
            null_q  <= 1'b0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            nerr_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            shift_q <= shift_d;
            null_q  <= null_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            nerr_q  <= nerr_d;
        end
    end

    assign adc_csn           = csn_q;
    assign adc_sck           = sck_q;
    assign adc_din           = din_q;
    assign host.Busy         = busy_q;
    assign host.Dout         = dout_q;
    assign host.DataValid    = dv_q;
    assign host.NullBitError = nerr_q;

endmodule
`default_nettype wire

// File: tb/tb_mercury2_adc_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mercury2_adc_reader
// Description : Directed self-checking bench for mercury2_adc_reader with a
//               behavioural MCP3008-style ADC model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mercury2_adc_reader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic adc_csn, adc_sck, adc_din;
    logic adc_dout = 1'b0;

    always #10 clk = ~clk;

    mercury2_adc_reader_if bus();

    mercury2_adc_reader #(
        .ClockFreq    (50_000_000),
        .SckFreq      (1_000_000),
        .CsHighClocks (50)
    ) dut (
        .clk_50MHZ (clk),
        .reset     (reset),
        .host      (bus),
        .adc_csn   (adc_csn),
        .adc_sck   (adc_sck),
        .adc_din   (adc_din),
        .adc_dout  (adc_dout)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event logs, in posedge-count units sampled at the falling clk edge
    int         csn_fall_t[$];
    int         csn_rise_t[$];
    int         busy_fall_t[$];
    int         dv_t[$];
    logic [9:0] dv_val[$];
    logic       dv_nerr[$];

    // ADC model state
    logic [9:0] mdl_data[32];
    logic       mdl_null[32];
    int         mdl_frame   = 0;
    logic [9:0] m_data      = '0;
    logic       m_null      = 1'b0;
    logic [4:0] m_cmd       = '0;
    int         m_rises     = 0;
    int         m_since     = 0;
    int         m_width_bad = 0;
    int         j;
    logic       prev_csn  = 1'b1;
    logic       prev_sck  = 1'b0;
    logic       prev_busy = 1'b0;

    // ADC model and event monitor
    always @(negedge clk) begin
        m_since++;
        if (prev_csn && !adc_csn) begin
            csn_fall_t.push_back(cyc);
            m_rises = 0;
            m_cmd   = '0;
            m_since = 0;
            m_data  = mdl_data[mdl_frame];
            m_null  = mdl_null[mdl_frame];
            mdl_frame++;
            adc_dout = 1'b0;
        end
        if (!prev_csn && adc_csn) csn_rise_t.push_back(cyc);
        if (!adc_csn && (adc_sck != prev_sck)) begin
            if (m_since != 25) m_width_bad++;
            m_since = 0;
            if (adc_sck) begin
                m_rises++;
                if (m_rises <= 5) m_cmd = {m_cmd[3:0], adc_din};
            end else begin
                j = m_rises;
                if (j == 6)                 adc_dout = m_null;
                else if (j >= 7 && j <= 16) adc_dout = m_data[16-j];
                else                        adc_dout = 1'b0;
            end
        end
        if (prev_busy && !bus.Busy) busy_fall_t.push_back(cyc);
        if (bus.DataValid) begin
            dv_t.push_back(cyc);
            dv_val.push_back(bus.Dout);
            dv_nerr.push_back(bus.NullBitError);
        end
        prev_csn  = adc_csn;
        prev_sck  = adc_sck;
        prev_busy = bus.Busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_logs();
        csn_fall_t.delete();
        csn_rise_t.delete();
        busy_fall_t.delete();
        dv_t.delete();
        dv_val.delete();
        dv_nerr.delete();
        m_width_bad = 0;
    endtask

    task automatic start();
        bus.trigger = 1'b1;
        base = cyc;
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic wait_falls(input int n, input string tag);
        int k;
        k = 0;
        while (busy_fall_t.size() < n && k < 5000) begin
            tick();
            k++;
        end
        check(tag, busy_fall_t.size(), n);
    endtask

    initial begin
        bus.trigger      = 1'b0;
        bus.channel      = 3'd0;
        bus.single_ended = 1'b0;

        // Reset and idle
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_logs();
        repeat (100) tick();
        check("idle_csn",  adc_csn, 1);
        check("idle_sck",  adc_sck, 0);
        check("idle_busy", bus.Busy, 0);
        check("idle_dout", bus.Dout, 0);
        check("idle_dv",   dv_t.size(), 0);

        // Single frame, channel 5 single-ended, result 0x2A5
        clear_logs();
        mdl_data[mdl_frame] = 10'h2A5;
        mdl_null[mdl_frame] = 1'b0;
        bus.channel      = 3'd5;
        bus.single_ended = 1'b1;
        start();
        check("f1_busy_t1", bus.Busy, 1);
        wait_falls(1, "f1_done");
        check("f1_csn_fall", csn_fall_t[0] - base, 1);
        check("f1_csn_rise", csn_rise_t[0] - base, 851);
        check("f1_rises",    m_rises, 17);
        check("f1_cmd",      m_cmd, 5'b11101);
        check("f1_width",    m_width_bad, 0);
        check("f1_dv_cnt",   dv_t.size(), 1);
        check("f1_dv_t",     dv_t[0] - base, 851);
        check("f1_dout",     dv_val[0], 10'h2A5);
        check("f1_nerr",     dv_nerr[0], 0);
        check("f1_busy_t",   busy_fall_t[0] - base, 901);
        check("f1_dout_hold", bus.Dout, 10'h2A5);

        // Back-to-back frames with trigger held high
        repeat (10) tick();
        clear_logs();
        mdl_data[mdl_frame]     = 10'h3FF;
        mdl_null[mdl_frame]     = 1'b0;
        mdl_data[mdl_frame + 1] = 10'h000;
        mdl_null[mdl_frame + 1] = 1'b0;
        bus.trigger = 1'b1;
        base = cyc;
        begin
            int k;
            k = 0;
            while (csn_fall_t.size() < 2 && k < 3000) begin
                tick();
                k++;
            end
        end
        bus.trigger = 1'b0;
        check("bb_two_starts", csn_fall_t.size(), 2);
        wait_falls(2, "bb_done");
        check("bb_gap",   csn_fall_t[1] - csn_rise_t[0], 51);
        check("bb_dv_n",  dv_val.size(), 2);
        check("bb_dout0", dv_val[0], 10'h3FF);
        check("bb_dout1", dv_val[1], 10'h000);
        check("bb_width", m_width_bad, 0);
        repeat (100) tick();
        check("bb_no_third", csn_fall_t.size(), 2);

        // Triggers during a frame are ignored; channel change has no effect
        clear_logs();
        mdl_data[mdl_frame] = 10'h0F0;
        mdl_null[mdl_frame] = 1'b0;
        bus.channel      = 3'd5;
        bus.single_ended = 1'b1;
        start();
        repeat (8) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (9) tick();
        bus.channel = 3'd2;
        while (cyc - base < 499) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        wait_falls(1, "ig_done");
        repeat (60) tick();
        check("ig_one_frame", csn_fall_t.size(), 1);
        check("ig_cmd",       m_cmd, 5'b11101);
        check("ig_dout",      dv_val[0], 10'h0F0);
        check("ig_dv_n",      dv_t.size(), 1);

        // Null bit error, then recovery on the next frame
        clear_logs();
        mdl_data[mdl_frame] = 10'h155;
        mdl_null[mdl_frame] = 1'b1;
        start();
        wait_falls(1, "nb1_done");
        check("nb1_nerr", bus.NullBitError, 1);
        check("nb1_dout", bus.Dout, 10'h155);
        repeat (5) tick();
        clear_logs();
        mdl_data[mdl_frame] = 10'h0C3;
        mdl_null[mdl_frame] = 1'b0;
        bus.channel      = 3'd6;
        bus.single_ended = 1'b0;
        start();
        wait_falls(1, "nb2_done");
        check("nb2_nerr", bus.NullBitError, 0);
        check("nb2_dout", bus.Dout, 10'h0C3);
        check("nb2_cmd",  m_cmd, 5'b10110);

        // Reset mid-frame
        repeat (5) tick();
        clear_logs();
        mdl_data[mdl_frame] = 10'h111;
        mdl_null[mdl_frame] = 1'b0;
        start();
        while (cyc - base < 400) tick();
        check("rst_pre_csn", adc_csn, 0);
        reset = 1'b1;
        #1;
        check("rst_csn",  adc_csn, 1);
        check("rst_sck",  adc_sck, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_dout", bus.Dout, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (950) tick();
        check("rst_no_dv", dv_t.size(), 0);

        // Normal frame after reset
        clear_logs();
        mdl_data[mdl_frame] = 10'h1E7;
        mdl_null[mdl_frame] = 1'b0;
        bus.channel      = 3'd3;
        bus.single_ended = 1'b0;
        start();
        wait_falls(1, "post_done");
        check("post_dout",  bus.Dout, 10'h1E7);
        check("post_cmd",   m_cmd, 5'b10011);
        check("post_rises", m_rises, 17);
        check("post_width", m_width_bad, 0);
        check("post_busy_t", busy_fall_t[0] - base, 901);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
